shifter_arbiter: RTL
====================

Name: shifter_arbiter

Overview:
- Shares one barrel-shift datapath between two requesters (ALU shift path = port 0, load/store byte-align path = port 1) of the MIPS-based soft processor.
- Round-robin arbitration, valid/ready handshake on each request port, registered result with backpressure, and the winner's id returned.
- Sustains one shift per cycle with 1-cycle latency.

Parameters:
N, 8, data width in bits (power of two, >=2)
SHW, 3, shift-amount width; equals log2(N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_data  in  N  port 0 operand
req0_sh  in  SHW  port 0 shift amount
req0_op  in  2  port 0 op: 00 SLL, 01 SRL, 10 ROL, 11 ROR
req1_valid / req1_ready / req1_data / req1_sh / req1_op  (same widths)  port 1 equivalents
res_valid  out  1  result register holds valid data
res_ready  in  1  consumer takes result this cycle
res_data  out  N  shifted result
res_id  out  1  port that issued the result
gnt_cnt0  out  16  requests accepted from port 0 (wraps)
gnt_cnt1  out  16  requests accepted from port 1 (wraps)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: res_valid=0, res_data=0, res_id=0, gnt_cnt0=gnt_cnt1=0, last_grant=1 (port 0 wins the first contention).
- Slot free: slot_free = !res_valid || res_ready.
- Grant (combinational):
  - Only one port valid: that port.
  - Both valid: the port != last_grant.
  - None valid: no grant.
- Ready: reqX_ready = grantX && slot_free. A ready is never asserted without the matching valid. At most one ready per cycle.
- Accept: at an edge with reqX_valid && reqX_ready:
  - res_data <= shift_core(reqX_data, reqX_sh, reqX_op); res_id <= X; res_valid <= 1.
  - last_grant <= X; gnt_cntX <= gnt_cntX + 1 (mod 2^16).
- Drain: at an edge with res_valid && res_ready and no accept, res_valid <= 0. Accept and drain in the same cycle keep res_valid=1 and load the new result (full throughput).
- Stall: res_valid && !res_ready holds res_data/res_id/res_valid stable, both readys are 0, and last_grant is unchanged.
- Request-side rule: a requester keeps valid and payload stable until ready. The arbiter does not latch requests, so payload changes before acceptance are simply used.
- Latency: 1 cycle from accept edge to res_valid.
- Fairness: with both ports continuously valid and res_ready=1, grants strictly alternate 0,1,0,1...
- Op semantics (shift_core), s = sh:
  - SLL: zero fill from LSB.
  - SRL: zero fill from MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - s=0 returns data unchanged for every op. s ranges 0..N-1 by width, so there is no overflow case.
- Reset mid-operation: a pending result is discarded (res_valid=0 the cycle after the rst edge), counters clear, and readys are 0 while rst=1.

Decomposition:
- Package shifter_pkg:
  - op encoding constants OP_SLL=2'b00, OP_SRL=2'b01, OP_ROL=2'b10, OP_ROR=2'b11.
  - default N/SHW.
  - port-id constants PORT_ALU=0, PORT_MEM=1.
- Sub-module shift_core (combinational; N, SHW; in, sh, op -> out): log2(N)-stage mux barrel shifter. shifter_arbiter instantiates exactly one shift_core on the granted port's payload.
- Arbitration, result register, and counters stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both valids high -> readys 0, res_valid=0, counters 0; after release port 0 granted first.
- Ops, N=8, port 0 only, res_ready=1, data=0xF0:
  - ROL 1 -> 0xE1; ROR 4 -> 0x0F; SRL 3 -> 0x1E; SLL 7 -> 0x00; any op sh=0 -> 0xF0.
  - Each result valid exactly 1 cycle after accept with res_id=0.
- Contention: both valid continuously for 6 cycles (port 0 data 0x81 ROL 1, port 1 data 0x81 SRL 1), res_ready=1 -> res_id sequence 0,1,0,1,0,1; data 0x03/0x40 alternating; gnt_cnt0=gnt_cnt1=3.
- Backpressure: accept a port 1 request for 0x3C SLL 2, then res_ready=0 for 3 cycles with port 0 valid -> res_data holds 0xF0, res_id=1, req0_ready=0. When res_ready=1, port 0 is accepted in that same cycle and its result appears next cycle.
- Back-to-back drain+accept: port 1 valid every cycle, res_ready=1 -> res_valid stays high continuously with one new result per cycle.
- Reset mid-stall: res_valid=1 and res_ready=0, pulse rst -> res_valid=0 and counters 0 next cycle; arbitration restarts with port 0 priority.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op encodings, default widths and port ids for the shift arbiter
package shifter_pkg;

    localparam int DEF_N   = 8;
    localparam int DEF_SHW = 3;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational log2(N)-stage mux barrel shifter (SLL/SRL/ROL/ROR)
module shift_core
    import shifter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int SHW = DEF_SHW
) (
    input  logic [N-1:0]   in,
    input  logic [SHW-1:0] sh,
    input  logic [1:0]     op,
    output logic [N-1:0]   out
);

    logic [N-1:0] stage [0:SHW];

    assign stage[0] = in;

    // Stage k moves by 2^k when sh[k] is set; 2^k never exceeds N/2, so both slices are non-empty.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int A = 1 << k;
        logic [N-1:0] moved;

        always_comb begin
            moved = stage[k];
            case (op)
                OP_SLL:  moved = {stage[k][N-1-A:0], {A{1'b0}}};
                OP_SRL:  moved = {{A{1'b0}}, stage[k][N-1:A]};
                OP_ROL:  moved = {stage[k][N-1-A:0], stage[k][N-1:N-A]};
                default: moved = {stage[k][A-1:0], stage[k][N-1:A]};
            endcase
        end

        assign stage[k+1] = sh[k] ? moved : stage[k];
    end

    assign out = stage[SHW];

endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin sharing of one barrel shifter between two requesters
module shifter_arbiter
    import shifter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int SHW = DEF_SHW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_data,
    input  logic [SHW-1:0] req0_sh,
    input  logic [1:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_data,
    input  logic [SHW-1:0] req1_sh,
    input  logic [1:0]     req1_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N-1:0]   res_data,
    output logic           res_id,
    output logic [15:0]    gnt_cnt0,
    output logic [15:0]    gnt_cnt1
);

    logic           res_valid_q, res_valid_d;
    logic [N-1:0]   res_data_q,  res_data_d;
    logic           res_id_q,    res_id_d;
    logic           last_grant_q, last_grant_d;
    logic [15:0]    gnt_cnt0_q,  gnt_cnt0_d;
    logic [15:0]    gnt_cnt1_q,  gnt_cnt1_d;

    logic           slot_free;
    logic           grant0, grant1;
    logic           accept0, accept1;
    logic [N-1:0]   core_in;
    logic [SHW-1:0] core_sh;
    logic [1:0]     core_op;
    logic [N-1:0]   core_out;

    // On contention the port that did not win last time goes first.
    assign slot_free = !res_valid_q || res_ready;
    assign grant0    = req0_valid && (!req1_valid || last_grant_q == PORT_MEM);
    assign grant1    = req1_valid && (!req0_valid || last_grant_q == PORT_ALU);
    assign accept0   = grant0 && slot_free && !rst;
    assign accept1   = grant1 && slot_free && !rst;

    assign req0_ready = accept0;
    assign req1_ready = accept1;

    assign core_in = grant1 ? req1_data : req0_data;
    assign core_sh = grant1 ? req1_sh   : req0_sh;
    assign core_op = grant1 ? req1_op   : req0_op;

    shift_core #(
        .N   (N),
        .SHW (SHW)
    ) u_shift_core (
        .in  (core_in),
        .sh  (core_sh),
        .op  (core_op),
        .out (core_out)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        gnt_cnt0_d   = gnt_cnt0_q;
        gnt_cnt1_d   = gnt_cnt1_q;

        if (accept0 || accept1) begin
            res_valid_d  = 1'b1;
            res_data_d   = core_out;
            res_id_d     = accept1 ? PORT_MEM : PORT_ALU;
            last_grant_d = accept1 ? PORT_MEM : PORT_ALU;
            if (accept0) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
            if (accept1) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= PORT_ALU;
            last_grant_q <= PORT_MEM;
            gnt_cnt0_q   <= 16'd0;
            gnt_cnt1_q   <= 16'd0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            gnt_cnt0_q   <= gnt_cnt0_d;
            gnt_cnt1_q   <= gnt_cnt1_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;

endmodule
